pixel_stream_capture: RTL and testbench
=======================================

Name: pixel_stream_capture

Overview:
- Downstream consumer of the pixel array's digital readout stream: the serial clock, start, done and data outputs of the pixel control macro.
- Synchronises these four signals into the wishbone clock domain and deserialises each readout frame into WORD_W-bit words.
- Buffers the words in a DEPTH-entry FIFO, where the management SoC or an LA/IO path drains them through a valid/ready pop port.
- Reports per-frame bit count, frame-done pulse and sticky overflow.

Parameters:
- WORD_W, 8, bits per captured word (min 2).
- DEPTH, 4, FIFO entries (power of two, min 2).
- CNT_W, 16, width of the frame bit counter.

Ports:
- wb_clk_i  in  1  system clock; all logic is on its rising edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable.
- pix_clk  in  1  serial clock from pixel macro, asynchronous, sampled as data.
- pix_start  in  1  frame start from pixel macro, async.
- pix_done  in  1  frame end from pixel macro, async.
- pix_data  in  1  serial data from pixel macro, async, MSB first.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  WORD_W  FIFO head word.
- rd_ready  in  1  pop request; pop occurs when rd_valid&rd_ready.
- fifo_level  out  $clog2(DEPTH+1)  occupied entries.
- busy  out  1  high in ACTIVE.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_bits  out  CNT_W  bits captured in last completed frame.
- overflow  out  1  sticky; a word was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, all synchroniser flops 0.
- Synchronisation:
  - pix_clk, pix_start, pix_done and pix_data each pass through an identical 2-FF synchroniser, so data stays aligned with clock.
  - A third register per control signal provides rising-edge detect; edges are one-cycle strobes.
  - Each strobe is valid in the cycle where sync2=1 and the edge register=0.
- State IDLE:
  - busy=0.
  - start edge with en=1 -> ACTIVE; shreg, bit_cnt and frame counter cleared.
  - clk and done edges are ignored.
- State ACTIVE:
  - On each pix_clk edge: shreg <= {shreg[WORD_W-2:0], data_sync}, bit_cnt++, frame counter++ (saturates at all-ones).
  - When the shifted bit is the WORD_W-th, {shreg[WORD_W-2:0], data_sync} is written to the FIFO on that same edge and bit_cnt returns to 0.
  - Additional start edges are ignored.
- Frame end (done edge in ACTIVE):
  - If bit_cnt != 0, shreg is pushed as the partial word, right-justified with upper bits zero.
  - frame_bits <= frame counter; frame_done=1 for one cycle; state -> IDLE.
  - Done on the same cycle as a clk edge: the bit is captured first, then frame end is processed, so a completing bit pushes a full word and no partial word is pushed.
- en=0:
  - State is forced to IDLE immediately; a partial word is discarded; no frame_done.
  - FIFO contents and the pop port are unaffected.
- Latency: rd_valid rises 3 wb_clk_i edges after the pix_clk pin edge carrying the word's last bit (pin to sync1, sync2, then capture plus FIFO write). The same 3-edge latency applies from pix_done pin to frame_done.
- FIFO:
  - Registered storage; no write-to-read bypass.
  - rd_data = head entry and is stable while rd_valid&!rd_ready.
  - Push and pop in the same cycle: both take effect, level unchanged. This includes the full case, where the push is accepted.
  - Push when full without a pop: word dropped, overflow set.
  - clr_ovf and a new overflow event in the same cycle: overflow stays 1.
  - Pointers wrap modulo DEPTH.
- Reset mid-frame returns to the reset state; the next start edge begins a clean frame.

Test Plan:
- Frame of 16 bits 0xA5 then 0x3C, rd_ready=1 -> words 0xA5, 0x3C; frame_done pulse; frame_bits=16; overflow=0.
- Frame of 12 bits 1111_0000_1011 -> words 0xF0, 0x0B; frame_bits=12.
- rd_ready=0, 40-bit frame (5 words 0x01..0x05) -> fifo_level=4, overflow=1; drain gives 0x01..0x04; clr_ovf -> overflow=0.
- FIFO full with rd_ready=1 held while the next word completes -> level stays 4, no overflow, order preserved.
- Reset asserted after 5 bits of a frame -> all outputs 0 asynchronously; next 8-bit frame 0x5A -> single word 0x5A, frame_bits=8.
- en=0 through a full frame -> no words, no frame_done; en deasserted mid-frame after 3 bits -> partial dropped, FIFO unchanged.

Source files
------------

// File: rtl/pixel_stream_capture.sv
// Captures the pixel macro's serial readout into WORD_W-bit words and buffers
// them in a small FIFO drained through a valid/ready pop port.
module pixel_stream_capture #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_n,
    input  logic                       en,
    input  logic                       pix_clk,
    input  logic                       pix_start,
    input  logic                       pix_done,
    input  logic                       pix_data,
    output logic                       rd_valid,
    output logic [WORD_W-1:0]          rd_data,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       busy,
    output logic                       frame_done,
    output logic [CNT_W-1:0]           frame_bits,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned BC_W  = $clog2(WORD_W + 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    // Synchroniser bit order: {data, done, start, clk}
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [2:0] edge_q;

    logic clk_rise;
    logic start_rise;
    logic done_rise;
    logic data_sync;

    logic [0:0]        state;
    logic [0:0]        state_n;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_n;
    logic [WORD_W-1:0] shifted;
    logic [BC_W-1:0]   bit_cnt;
    logic [BC_W-1:0]   bit_cnt_n;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  frame_cnt_n;
    logic [CNT_W-1:0]  frame_bits_n;
    logic              done_evt;
    logic              push;
    logic [WORD_W-1:0] push_word;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  wr_ptr_n;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_n;
    logic [LVL_W-1:0]  level_n;
    logic [WORD_W-1:0] head_n;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic              ovf_set;
    logic              overflow_n;

    // Two-stage synchronisers plus a third stage for rising-edge detect
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= {pix_data, pix_done, pix_start, pix_clk};
            sync2  <= sync1;
            edge_q <= sync2[2:0];
        end
    end

    assign clk_rise   = sync2[0] & ~edge_q[0];
    assign start_rise = sync2[1] & ~edge_q[1];
    assign done_rise  = sync2[2] & ~edge_q[2];
    assign data_sync  = sync2[3];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Frame capture: the clock edge is applied before any coincident done edge
    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        bit_cnt_n    = bit_cnt;
        frame_cnt_n  = frame_cnt;
        frame_bits_n = frame_bits;
        done_evt     = 1'b0;
        push         = 1'b0;
        push_word    = '0;
        shifted      = {shreg[WORD_W-2:0], data_sync};

        case (state)
            S_IDLE: begin
                if (en && start_rise) begin
                    state_n     = S_ACTIVE;
                    shreg_n     = '0;
                    bit_cnt_n   = '0;
                    frame_cnt_n = '0;
                end
            end
            S_ACTIVE: begin
                if (!en) begin
                    state_n = S_IDLE;
                end else begin
                    if (clk_rise) begin
                        if (frame_cnt != '1) begin
                            frame_cnt_n = frame_cnt + CNT_W'(1);
                        end
                        if (bit_cnt == BC_W'(WORD_W - 1)) begin
                            push      = 1'b1;
                            push_word = shifted;
                            shreg_n   = '0;
                            bit_cnt_n = '0;
                        end else begin
                            shreg_n   = shifted;
                            bit_cnt_n = bit_cnt + BC_W'(1);
                        end
                    end
                    if (done_rise) begin
                        // shreg is zeroed after every full word, so a partial is already right-justified
                        if (bit_cnt_n != '0) begin
                            push      = 1'b1;
                            push_word = shreg_n;
                        end
                        frame_bits_n = frame_cnt_n;
                        done_evt     = 1'b1;
                        state_n      = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FIFO control; a push into a full FIFO is accepted when a pop frees a slot
    always_comb begin
        pop      = rd_valid & rd_ready;
        full     = (fifo_level == LVL_W'(DEPTH));
        wr_en    = push & (~full | pop);
        ovf_set  = push & full & ~pop;
        wr_ptr_n = wr_en ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_n = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

        level_n = fifo_level;
        case ({wr_en, pop})
            2'b10:   level_n = fifo_level + LVL_W'(1);
            2'b01:   level_n = fifo_level - LVL_W'(1);
            default: level_n = fifo_level;
        endcase

        // Head register tracks the entry at the next read pointer, including a word landing there now
        if (wr_en && (wr_ptr == rd_ptr_n)) begin
            head_n = push_word;
        end else begin
            head_n = mem[rd_ptr_n];
        end

        overflow_n = ovf_set | (overflow & ~clr_ovf);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            frame_cnt  <= '0;
            frame_bits <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            frame_cnt  <= frame_cnt_n;
            frame_bits <= frame_bits_n;
            frame_done <= done_evt;
            busy       <= (state_n == S_ACTIVE);
            overflow   <= overflow_n;
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            fifo_level <= level_n;
            rd_valid   <= (level_n != '0);
            rd_data    <= head_n;
            if (wr_en) begin
                mem[wr_ptr] <= push_word;
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_capture.sv
// Directed and randomized frames for pixel_stream_capture, checked against a
// queue-based model of frame slicing and FIFO behaviour.
module tb_pixel_stream_capture;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 16;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_n = 1'b0;
    logic              en = 1'b1;
    logic              pix_clk = 1'b0;
    logic              pix_start = 1'b0;
    logic              pix_done = 1'b0;
    logic              pix_data = 1'b0;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;
    logic              rd_ready = 1'b0;
    logic [2:0]        fifo_level;
    logic              busy;
    logic              frame_done;
    logic [CNT_W-1:0]  frame_bits;
    logic              overflow;
    logic              clr_ovf = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic        tx_bits [$];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];

    pixel_stream_capture #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n  (wb_rst_n),
        .en        (en),
        .pix_clk   (pix_clk),
        .pix_start (pix_start),
        .pix_done  (pix_done),
        .pix_data  (pix_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .fifo_level(fifo_level),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_bits(frame_bits),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Record every pop and every frame_done cycle, sampled mid-cycle
    always @(negedge wb_clk_i) begin
        if (rd_valid && rd_ready) got_q.push_back(32'(rd_data));
        if (frame_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk_i);
        #2;
    endtask

    task automatic pix_bit(input logic b);
        pix_data = b;
        pix_clk  = 1'b0;
        tick(3);
        pix_clk = 1'b1;
        tick(3);
    endtask

    task automatic start_frame();
        pix_clk   = 1'b0;
        pix_start = 1'b1;
        tick(3);
        pix_start = 1'b0;
        tick(3);
    endtask

    task automatic end_frame();
        pix_clk  = 1'b0;
        pix_done = 1'b1;
        tick(3);
        pix_done = 1'b0;
        tick(8);
    endtask

    task automatic send_frame();
        start_frame();
        foreach (tx_bits[i]) pix_bit(tx_bits[i]);
        end_frame();
    endtask

    task automatic load_value(input logic [31:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) tx_bits.push_back(v[i]);
    endtask

    // Word k is bits [k*W, k*W+W) read MSB first; a short tail is right-justified
    function automatic void build_expected();
        exp_q.delete();
        for (int k = 0; k < tx_bits.size(); k += WORD_W) begin
            int n;
            logic [31:0] v;
            n = tx_bits.size() - k;
            if (n > int'(WORD_W)) n = WORD_W;
            v = 0;
            for (int j = 0; j < n; j++) v = v * 2 + 32'(tx_bits[k + j]);
            exp_q.push_back(v);
        end
    endfunction

    task automatic check_words(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rd_data"}, 32'(rd_data), 0);
        check({tag, "_level"}, 32'(fifo_level), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_frame_bits"}, 32'(frame_bits), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    initial begin
        int d0;
        int nb;
        logic [31:0] fill [$];

        // Reset
        tick(3);
        check_reset_outputs("reset");
        wb_rst_n = 1'b1;
        tick(2);

        // Two full words, drained as they arrive
        rd_ready = 1'b1;
        tx_bits.delete(); got_q.delete();
        load_value(32'hA5, 8); load_value(32'h3C, 8);
        build_expected();
        d0 = done_cnt;
        start_frame();
        pix_bit(tx_bits[0]);
        check("busy_active", 32'(busy), 1);
        for (int i = 1; i < tx_bits.size(); i++) pix_bit(tx_bits[i]);
        end_frame();
        check_words("a5_3c");
        check("a5_3c_done", 32'(done_cnt - d0), 1);
        check("a5_3c_bits", 32'(frame_bits), 16);
        check("a5_3c_ovf", 32'(overflow), 0);
        check("a5_3c_busy", 32'(busy), 0);

        // 12-bit frame with partial tail
        tx_bits.delete(); got_q.delete();
        load_value(32'hF0B, 12);
        build_expected();
        send_frame();
        check_words("f0_0b");
        check("f0_0b_bits", 32'(frame_bits), 12);

        // Five words into a four-entry FIFO with no reader
        rd_ready = 1'b0;
        tx_bits.delete(); got_q.delete();
        for (int i = 1; i <= 5; i++) load_value(32'(i), 8);
        send_frame();
        check("ovf_level", 32'(fifo_level), 4);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_head", 32'(rd_data), 1);
        check("ovf_bits", 32'(frame_bits), 40);
        exp_q.delete();
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
        rd_ready = 1'b1;
        tick(8);
        rd_ready = 1'b0;
        check_words("ovf_drain");
        check("ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("ovf_clear", 32'(overflow), 0);

        // Full FIFO with a pop landing on the same edge as the next push
        tx_bits.delete(); got_q.delete(); fill.delete();
        for (int i = 0; i < 4; i++) begin
            fill.push_back(32'($urandom_range(0, 255)));
            load_value(fill[i], 8);
        end
        send_frame();
        check("full_level", 32'(fifo_level), 4);
        tx_bits.delete();
        fill.push_back(32'($urandom_range(0, 255)));
        load_value(fill[4], 8);
        start_frame();
        for (int i = 0; i < 7; i++) pix_bit(tx_bits[i]);
        pix_data = tx_bits[7];
        pix_clk  = 1'b0;
        tick(3);
        pix_clk = 1'b1;
        tick(2);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        check("full_pushpop_level", 32'(fifo_level), 4);
        check("full_pushpop_ovf", 32'(overflow), 0);
        end_frame();
        rd_ready = 1'b1;
        tick(8);
        rd_ready = 1'b0;
        exp_q = fill;
        check_words("full_order");

        // Asynchronous reset mid-frame, then a clean frame
        tx_bits.delete(); got_q.delete();
        load_value(32'h1F, 5);
        start_frame();
        foreach (tx_bits[i]) pix_bit(tx_bits[i]);
        #3;
        wb_rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        pix_clk = 1'b0;
        pix_data = 1'b0;
        tick(3);
        wb_rst_n = 1'b1;
        tick(3);
        rd_ready = 1'b1;
        tx_bits.delete(); got_q.delete();
        load_value(32'h5A, 8);
        build_expected();
        send_frame();
        check_words("post_reset");
        check("post_reset_bits", 32'(frame_bits), 8);

        // Disabled capture across a whole frame
        en = 1'b0;
        tx_bits.delete(); got_q.delete();
        load_value(32'hC3, 8);
        d0 = done_cnt;
        send_frame();
        check("en0_words", 32'(got_q.size()), 0);
        check("en0_done", 32'(done_cnt - d0), 0);
        check("en0_level", 32'(fifo_level), 0);
        en = 1'b1;

        // Enable dropped mid-frame with a word already buffered
        rd_ready = 1'b0;
        tx_bits.delete(); got_q.delete();
        load_value(32'h96, 8);
        send_frame();
        tx_bits.delete();
        d0 = done_cnt;
        start_frame();
        for (int i = 0; i < 3; i++) pix_bit(1'b1);
        en = 1'b0;
        tick(2);
        check("en_drop_busy", 32'(busy), 0);
        for (int i = 0; i < 5; i++) pix_bit(1'b1);
        end_frame();
        check("en_drop_level", 32'(fifo_level), 1);
        check("en_drop_done", 32'(done_cnt - d0), 0);
        en = 1'b1;
        rd_ready = 1'b1;
        tick(4);
        exp_q.delete();
        exp_q.push_back(32'h96);
        check_words("en_drop_fifo");

        // Random frames; some end with the last clock edge and done together
        for (int f = 0; f < 6; f++) begin
            tx_bits.delete(); got_q.delete();
            nb = (f < 2) ? 16 + f : int'($urandom_range(1, 30));
            for (int i = 0; i < nb; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
            build_expected();
            d0 = done_cnt;
            start_frame();
            if (f < 2) begin
                for (int i = 0; i < nb - 1; i++) pix_bit(tx_bits[i]);
                pix_data = tx_bits[nb - 1];
                pix_clk  = 1'b0;
                tick(3);
                pix_clk  = 1'b1;
                pix_done = 1'b1;
                tick(3);
                pix_clk  = 1'b0;
                pix_done = 1'b0;
                tick(8);
            end else begin
                foreach (tx_bits[i]) pix_bit(tx_bits[i]);
                end_frame();
            end
            check_words($sformatf("rand%0d", f));
            check($sformatf("rand%0d_bits", f), 32'(frame_bits), 32'(nb));
            check($sformatf("rand%0d_done", f), 32'(done_cnt - d0), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
